branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Bimodal branch predictor at the far end of the datapath's branch-predict interface.
- Predicts taken/not-taken for branches and early jumps in ID and drives the fetch redirect.
- Carries each prediction through the EX and MEM slots so `jump_taken` lines up with the instruction the datapath resolves in MEM.
- Trains a table of 2-bit saturating counters from the datapath's `branch_resolved` / `actual_taken` outcome.

Parameters:
- INDEX_BITS, 6, log2 of counter-table entries (64 entries).
- INIT_STATE, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- id_pc  in  32  PC of the instruction in ID
- id_is_branch  in  1  ID instruction is a conditional branch
- id_jump_early  in  1  ID instruction is a jump whose target is resolved in ID
- stall  in  1  ID held this cycle; a bubble enters EX
- flush  in  1  wrong-path squash of the ID and EX instructions
- branch_resolved  in  1  MEM-stage branch resolved this cycle
- actual_taken  in  1  resolved direction, qualified by branch_resolved
- mispredict  in  1  MEM-stage prediction was wrong, qualified by branch_resolved
- predict_taken  out  1  combinational ID prediction, used for fetch redirect
- jump_taken  out  1  registered prediction tag of the MEM-stage instruction

Behaviour:
- Table: 2^INDEX_BITS entries of 2-bit counters. Index is id_pc[INDEX_BITS+1:2].
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- predict_taken = id_jump_early | (id_is_branch & ctr[idx][1]). It is 0 when neither input is set.
- Slots: EX and MEM each hold {valid, taken, idx}.
- Per rising clk, in priority order:
  - flush: EX and MEM are both cleared (valid=0, taken=0). Flush overrides stall.
  - stall: MEM <= EX; EX <= bubble.
  - otherwise: MEM <= EX; EX <= {id_is_branch|id_jump_early, predict_taken, idx}.
- jump_taken = MEM.valid & MEM.taken. Latency from ID to jump_taken is 2 unstalled cycles.
- Training: when branch_resolved=1 and MEM.valid=1, ctr[MEM.idx] updates on the same clk edge.
  - actual_taken=1: increment, saturating at 11.
  - actual_taken=0: decrement, saturating at 00.
- branch_resolved=1 with MEM.valid=0 is ignored; no table write occurs.
- Jumps are never trained. The datapath holds branch_resolved low for jumps.
- Same-index read and write in one cycle: the ID prediction uses the pre-update value. There is no bypass.
- Training and flush in the same cycle: the table update uses the MEM slot value before the clear. This is the normal mispredict case.
- mispredict does not affect the table. It only feeds the optional statistics.
- Reset (rst=0, any time, including mid-pipeline):
  - every counter goes to INIT_STATE;
  - EX and MEM are cleared;
  - jump_taken=0;
  - stat counters (if present) are 0.
  - predict_taken follows the inputs against the reset table.
- Pipeline slots and outputs have no X states after reset.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined: adds outputs stat_branches [31:0] and stat_mispredicts [31:0].
  - stat_branches increments on each accepted training (branch_resolved & MEM.valid).
  - stat_mispredicts increments when that training also has mispredict=1.
  - Both wrap modulo 2^32 and clear on reset.
- Undefined: neither port nor counter exists, and all other behaviour is identical.

Test Plan:
- Reset, then id_is_branch=1, id_pc=0x40 → predict_taken=0 (counter 01). Two cycles later jump_taken=0.
- Same pc resolved taken twice (branch_resolved=1, actual_taken=1 each pass) → counter 01→10→11. Next ID branch at 0x40 gives predict_taken=1, and two cycles later jump_taken=1.
- Saturation:
  - 4 taken trainings on one index leave the counter at 11;
  - 4 not-taken trainings then reach 00;
  - a 5th not-taken training stays at 00, and predict_taken stays 0.
- id_jump_early=1 → predict_taken=1. jump_taken=1 two cycles later, with no table change.
- Branch in EX, flush=1 → next cycle jump_taken=0. A branch_resolved pulse the following cycle causes no write.
- stall=1 for 1 cycle while a predicted-taken branch sits in ID → jump_taken goes 1 three cycles after ID entry.
- Asserting rst mid-run → jump_taken=0 immediately and all counters return to 01.
- With BP_STATS_EN: 3 trainings, 1 with mispredict → stat_branches=3, stat_mispredicts=1.

Source files
------------

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit counter table, EX/MEM prediction tags.
// Define BP_STATS_EN to add branch/mispredict statistics counters.
module branch_predictor #(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_pc,
  input  logic        id_is_branch,
  input  logic        id_jump_early,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_resolved,
  input  logic        actual_taken,
  input  logic        mispredict,
  output logic        predict_taken,
  output logic        jump_taken
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            ctr [ENTRIES];
  logic [INDEX_BITS-1:0] idx;
  logic [1:0]            cur;
  logic                  ex_valid;
  logic                  ex_taken;
  logic [INDEX_BITS-1:0] ex_idx;
  logic                  mem_valid;
  logic                  mem_taken;
  logic [INDEX_BITS-1:0] mem_idx;
  logic                  train;
  logic                  unused_pc;

  assign idx = id_pc[INDEX_BITS+1:2];
  assign cur = ctr[idx];
  assign unused_pc = ^{id_pc[31:INDEX_BITS+2], id_pc[1:0]};

  assign predict_taken = id_jump_early | (id_is_branch & cur[1]);
  assign jump_taken    = mem_valid & mem_taken;
  assign train         = branch_resolved & mem_valid;

  // Counter table: saturating train from the MEM slot's index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= INIT_STATE;
    end else if (train) begin
      if (actual_taken) begin
        if (ctr[mem_idx] != 2'b11)
          ctr[mem_idx] <= ctr[mem_idx] + 2'd1;
      end else begin
        if (ctr[mem_idx] != 2'b00)
          ctr[mem_idx] <= ctr[mem_idx] - 2'd1;
      end
    end
  end

  // EX/MEM prediction tags; flush beats stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid  <= 1'b0;
      ex_taken  <= 1'b0;
      ex_idx    <= '0;
      mem_valid <= 1'b0;
      mem_taken <= 1'b0;
      mem_idx   <= '0;
    end else if (flush) begin
      ex_valid  <= 1'b0;
      ex_taken  <= 1'b0;
      mem_valid <= 1'b0;
      mem_taken <= 1'b0;
    end else if (stall) begin
      mem_valid <= ex_valid;
      mem_taken <= ex_taken;
      mem_idx   <= ex_idx;
      ex_valid  <= 1'b0;
      ex_taken  <= 1'b0;
    end else begin
      mem_valid <= ex_valid;
      mem_taken <= ex_taken;
      mem_idx   <= ex_idx;
      ex_valid  <= id_is_branch | id_jump_early;
      ex_taken  <= predict_taken;
      ex_idx    <= idx;
    end
  end

`ifdef BP_STATS_EN
  // Count accepted trainings and the mispredicted subset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (train) begin
      stat_branches <= stat_branches + 32'd1;
      if (mispredict)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`else
  logic unused_mp;
  assign unused_mp = mispredict;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus random traffic
// against a counter-array / queue reference model.
module tb_branch_predictor;

  localparam int IB = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_pc;
  logic        id_is_branch;
  logic        id_jump_early;
  logic        stall;
  logic        flush;
  logic        branch_resolved;
  logic        actual_taken;
  logic        mispredict;
  logic        predict_taken;
  logic        jump_taken;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_predictor #(.INDEX_BITS(IB), .INIT_STATE(2'b01)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_pc           (id_pc),
    .id_is_branch    (id_is_branch),
    .id_jump_early   (id_jump_early),
    .stall           (stall),
    .flush           (flush),
    .branch_resolved (branch_resolved),
    .actual_taken    (actual_taken),
    .mispredict      (mispredict),
    .predict_taken   (predict_taken),
    .jump_taken      (jump_taken)
`ifdef BP_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit v;
    bit t;
    int idx;
  } slot_t;

  typedef struct {
    bit          br;
    bit          je;
    logic [31:0] pc;
    bit          st;
    bit          fl;
    bit          res;
    bit          act;
    bit          mp;
    int          ep;
    int          ej;
  } stim_t;

  int          ctr_m [1<<IB];
  slot_t       pipe [$];
  int unsigned sb_m;
  int unsigned sm_m;
  stim_t       sq [$];

  function automatic int pidx(logic [31:0] pc);
    return int'(pc[IB+1:2]);
  endfunction

  function automatic bit m_pred();
    return id_jump_early || (id_is_branch && ctr_m[pidx(id_pc)] >= 2);
  endfunction

  function automatic bit m_jt();
    return pipe[1].v && pipe[1].t;
  endfunction

  function automatic void model_reset();
    slot_t z = '{0, 0, 0};
    foreach (ctr_m[i]) ctr_m[i] = 1;
    pipe.delete();
    pipe.push_back(z);
    pipe.push_back(z);
    sb_m = 0;
    sm_m = 0;
  endfunction

  function automatic void model_edge();
    slot_t z = '{0, 0, 0};
    slot_t nx;
    bit    p  = m_pred();
    int    mi = pipe[1].idx;
    if (branch_resolved && pipe[1].v) begin
      sb_m++;
      if (mispredict) sm_m++;
      if (actual_taken) ctr_m[mi] = (ctr_m[mi] == 3) ? 3 : ctr_m[mi] + 1;
      else              ctr_m[mi] = (ctr_m[mi] == 0) ? 0 : ctr_m[mi] - 1;
    end
    nx = '{id_is_branch || id_jump_early, p, pidx(id_pc)};
    void'(pipe.pop_back());
    if (flush) begin
      pipe.delete();
      pipe.push_back(z);
      pipe.push_back(z);
    end else if (stall) begin
      pipe.push_front(z);
    end else begin
      pipe.push_front(nx);
    end
  endfunction

  function automatic stim_t mk(bit br = 0, bit je = 0,
                               logic [31:0] pc = 0, bit st = 0,
                               bit fl = 0, bit res = 0, bit act = 0,
                               bit mp = 0, int ep = -1, int ej = -1);
    stim_t s;
    s.br = br; s.je = je; s.pc = pc; s.st = st; s.fl = fl;
    s.res = res; s.act = act; s.mp = mp; s.ep = ep; s.ej = ej;
    return s;
  endfunction

  function automatic void add_pass(logic [31:0] pc, bit act, bit mp, int ep);
    sq.push_back(mk(.br(1), .pc(pc), .ep(ep)));
    sq.push_back(mk());
    sq.push_back(mk(.res(1), .act(act), .mp(mp), .ej(ep)));
  endfunction

  task automatic apply(stim_t s);
    id_is_branch    = s.br;
    id_jump_early   = s.je;
    id_pc           = s.pc;
    stall           = s.st;
    flush           = s.fl;
    branch_resolved = s.res;
    actual_taken    = s.act;
    mispredict      = s.mp;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    apply(mk(.br(1), .pc(32'h40)));
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (predict_taken !== 1'b0) begin
      n_err++;
      $display("FAIL rst_pred got=%b exp=0", predict_taken);
    end
    n_cmp++;
    if (jump_taken !== 1'b0) begin
      n_err++;
      $display("FAIL rst_jt got=%b exp=0", jump_taken);
    end
`ifdef BP_STATS_EN
    n_cmp++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      n_err++;
      $display("FAIL rst_stats got=%0d/%0d exp=0/0",
               stat_branches, stat_mispredicts);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    sq.push_back(mk(.br(1), .pc(32'h40), .ep(0), .ej(0)));
    sq.push_back(mk(.ej(0)));
    sq.push_back(mk(.ej(0)));
    foreach (sq[k]) begin
      apply(sq[k]);
      @(negedge clk);
      n_cmp++;
      if (predict_taken !== m_pred() ||
          (sq[k].ep >= 0 && predict_taken !== 1'(sq[k].ep))) begin
        n_err++;
        $display("FAIL reset_pred k=%0d got=%b model=%b ep=%0d",
                 k, predict_taken, m_pred(), sq[k].ep);
      end
      n_cmp++;
      if (jump_taken !== m_jt() ||
          (sq[k].ej >= 0 && jump_taken !== 1'(sq[k].ej))) begin
        n_err++;
        $display("FAIL reset_jt k=%0d got=%b model=%b ej=%0d",
                 k, jump_taken, m_jt(), sq[k].ej);
      end
      tick();
    end
    sq.delete();
  endtask

  task automatic test_train();
    add_pass(32'h40, 1, 0, 0);
    add_pass(32'h40, 1, 0, 1);
    sq.push_back(mk(.br(1), .pc(32'h40), .ep(1)));
    sq.push_back(mk());
    sq.push_back(mk(.ej(1)));
    foreach (sq[k]) begin
      apply(sq[k]);
      @(negedge clk);
      n_cmp++;
      if (predict_taken !== m_pred() ||
          (sq[k].ep >= 0 && predict_taken !== 1'(sq[k].ep))) begin
        n_err++;
        $display("FAIL train_pred k=%0d got=%b model=%b ep=%0d",
                 k, predict_taken, m_pred(), sq[k].ep);
      end
      n_cmp++;
      if (jump_taken !== m_jt() ||
          (sq[k].ej >= 0 && jump_taken !== 1'(sq[k].ej))) begin
        n_err++;
        $display("FAIL train_jt k=%0d got=%b model=%b ej=%0d",
                 k, jump_taken, m_jt(), sq[k].ej);
      end
      tick();
    end
    sq.delete();
  endtask

  task automatic test_saturation();
    int ep_tab [11] = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    for (int p = 0; p < 11; p++)
      add_pass(32'h80, (p < 4 || p > 8), 0, ep_tab[p]);
    sq.push_back(mk(.br(1), .pc(32'h80), .ep(1)));
    foreach (sq[k]) begin
      apply(sq[k]);
      @(negedge clk);
      n_cmp++;
      if (predict_taken !== m_pred() ||
          (sq[k].ep >= 0 && predict_taken !== 1'(sq[k].ep))) begin
        n_err++;
        $display("FAIL sat_pred k=%0d got=%b model=%b ep=%0d",
                 k, predict_taken, m_pred(), sq[k].ep);
      end
      n_cmp++;
      if (jump_taken !== m_jt() ||
          (sq[k].ej >= 0 && jump_taken !== 1'(sq[k].ej))) begin
        n_err++;
        $display("FAIL sat_jt k=%0d got=%b model=%b ej=%0d",
                 k, jump_taken, m_jt(), sq[k].ej);
      end
      tick();
    end
    sq.delete();
  endtask

  task automatic test_flush();
    sq.push_back(mk());
    sq.push_back(mk());
    sq.push_back(mk(.br(1), .pc(32'h80), .ep(1)));
    sq.push_back(mk(.st(1), .fl(1), .ej(0)));
    sq.push_back(mk(.res(1), .act(0), .ej(0)));
    sq.push_back(mk(.br(1), .pc(32'h80), .ep(1), .ej(0)));
    foreach (sq[k]) begin
      apply(sq[k]);
      @(negedge clk);
      n_cmp++;
      if (predict_taken !== m_pred() ||
          (sq[k].ep >= 0 && predict_taken !== 1'(sq[k].ep))) begin
        n_err++;
        $display("FAIL flush_pred k=%0d got=%b model=%b ep=%0d",
                 k, predict_taken, m_pred(), sq[k].ep);
      end
      n_cmp++;
      if (jump_taken !== m_jt() ||
          (sq[k].ej >= 0 && jump_taken !== 1'(sq[k].ej))) begin
        n_err++;
        $display("FAIL flush_jt k=%0d got=%b model=%b ej=%0d",
                 k, jump_taken, m_jt(), sq[k].ej);
      end
      tick();
    end
    sq.delete();
  endtask

  task automatic test_jump();
    sq.push_back(mk(.je(1), .pc(32'hC0), .ep(1)));
    sq.push_back(mk(.pc(32'h40), .ep(0)));
    sq.push_back(mk(.ej(1)));
    sq.push_back(mk(.br(1), .pc(32'hC0), .ep(0), .ej(0)));
    sq.push_back(mk());
    sq.push_back(mk());
    foreach (sq[k]) begin
      apply(sq[k]);
      @(negedge clk);
      n_cmp++;
      if (predict_taken !== m_pred() ||
          (sq[k].ep >= 0 && predict_taken !== 1'(sq[k].ep))) begin
        n_err++;
        $display("FAIL jump_pred k=%0d got=%b model=%b ep=%0d",
                 k, predict_taken, m_pred(), sq[k].ep);
      end
      n_cmp++;
      if (jump_taken !== m_jt() ||
          (sq[k].ej >= 0 && jump_taken !== 1'(sq[k].ej))) begin
        n_err++;
        $display("FAIL jump_jt k=%0d got=%b model=%b ej=%0d",
                 k, jump_taken, m_jt(), sq[k].ej);
      end
      tick();
    end
    sq.delete();
  endtask

  task automatic test_stall();
    sq.push_back(mk(.br(1), .pc(32'h40), .st(1), .ep(1), .ej(0)));
    sq.push_back(mk(.br(1), .pc(32'h40), .ep(1), .ej(0)));
    sq.push_back(mk(.ej(0)));
    sq.push_back(mk(.ej(1)));
    sq.push_back(mk(.ej(0)));
    foreach (sq[k]) begin
      apply(sq[k]);
      @(negedge clk);
      n_cmp++;
      if (predict_taken !== m_pred() ||
          (sq[k].ep >= 0 && predict_taken !== 1'(sq[k].ep))) begin
        n_err++;
        $display("FAIL stall_pred k=%0d got=%b model=%b ep=%0d",
                 k, predict_taken, m_pred(), sq[k].ep);
      end
      n_cmp++;
      if (jump_taken !== m_jt() ||
          (sq[k].ej >= 0 && jump_taken !== 1'(sq[k].ej))) begin
        n_err++;
        $display("FAIL stall_jt k=%0d got=%b model=%b ej=%0d",
                 k, jump_taken, m_jt(), sq[k].ej);
      end
      tick();
    end
    sq.delete();
  endtask

  task automatic test_same_index();
    sq.push_back(mk(.br(1), .pc(32'hC0), .ep(0)));
    sq.push_back(mk());
    sq.push_back(mk(.br(1), .pc(32'hC0), .res(1), .act(1), .ep(0), .ej(0)));
    sq.push_back(mk(.br(1), .pc(32'hC0), .ep(1)));
    sq.push_back(mk());
    sq.push_back(mk());
    foreach (sq[k]) begin
      apply(sq[k]);
      @(negedge clk);
      n_cmp++;
      if (predict_taken !== m_pred() ||
          (sq[k].ep >= 0 && predict_taken !== 1'(sq[k].ep))) begin
        n_err++;
        $display("FAIL same_pred k=%0d got=%b model=%b ep=%0d",
                 k, predict_taken, m_pred(), sq[k].ep);
      end
      n_cmp++;
      if (jump_taken !== m_jt() ||
          (sq[k].ej >= 0 && jump_taken !== 1'(sq[k].ej))) begin
        n_err++;
        $display("FAIL same_jt k=%0d got=%b model=%b ej=%0d",
                 k, jump_taken, m_jt(), sq[k].ej);
      end
      tick();
    end
    sq.delete();
  endtask

  task automatic test_random();
    stim_t       s;
    logic [31:0] pc;
    for (int i = 0; i < 400; i++) begin
      pc = $urandom;
      pc[IB+1:2] = 6'($urandom_range(0, 3));
      s = mk(.br($urandom_range(0, 1) == 1),
             .je($urandom_range(0, 9) == 0),
             .pc(pc),
             .st($urandom_range(0, 6) == 0),
             .fl($urandom_range(0, 11) == 0),
             .res($urandom_range(0, 1) == 1),
             .act($urandom_range(0, 1) == 1),
             .mp($urandom_range(0, 2) == 0));
      apply(s);
      @(negedge clk);
      n_cmp++;
      if (predict_taken !== m_pred()) begin
        n_err++;
        $display("FAIL rand_pred i=%0d got=%b exp=%b",
                 i, predict_taken, m_pred());
      end
      n_cmp++;
      if (jump_taken !== m_jt()) begin
        n_err++;
        $display("FAIL rand_jt i=%0d got=%b exp=%b",
                 i, jump_taken, m_jt());
      end
`ifdef BP_STATS_EN
      n_cmp++;
      if (stat_branches !== sb_m || stat_mispredicts !== sm_m) begin
        n_err++;
        $display("FAIL rand_stats i=%0d got=%0d/%0d exp=%0d/%0d",
                 i, stat_branches, stat_mispredicts, sb_m, sm_m);
      end
`endif
      tick();
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] pcs [4] = '{32'h40, 32'h80, 32'h0, 32'hFC};
    apply(mk(.br(1), .pc(32'h40)));
    tick();
    apply(mk());
    tick();
    #1;
    n_cmp++;
    if (jump_taken !== 1'b1 || m_jt() !== 1'b1) begin
      n_err++;
      $display("FAIL mrst_pre_jt got=%b model=%b exp=1", jump_taken, m_jt());
    end
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (jump_taken !== 1'b0) begin
      n_err++;
      $display("FAIL mrst_jt got=%b exp=0", jump_taken);
    end
    apply(mk(.br(1), .pc(32'h40)));
    #1;
    n_cmp++;
    if (predict_taken !== 1'b0) begin
      n_err++;
      $display("FAIL mrst_pred got=%b exp=0", predict_taken);
    end
`ifdef BP_STATS_EN
    n_cmp++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      n_err++;
      $display("FAIL mrst_stats got=%0d/%0d exp=0/0",
               stat_branches, stat_mispredicts);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    foreach (pcs[j]) begin
      add_pass(pcs[j], 1, 0, 0);
      sq.push_back(mk(.br(1), .pc(pcs[j]), .ep(1)));
      sq.push_back(mk());
      sq.push_back(mk());
    end
    foreach (sq[k]) begin
      apply(sq[k]);
      @(negedge clk);
      n_cmp++;
      if (predict_taken !== m_pred() ||
          (sq[k].ep >= 0 && predict_taken !== 1'(sq[k].ep))) begin
        n_err++;
        $display("FAIL mrst_tbl_pred k=%0d got=%b model=%b ep=%0d",
                 k, predict_taken, m_pred(), sq[k].ep);
      end
      n_cmp++;
      if (jump_taken !== m_jt()) begin
        n_err++;
        $display("FAIL mrst_tbl_jt k=%0d got=%b exp=%b",
                 k, jump_taken, m_jt());
      end
      tick();
    end
    sq.delete();
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats();
    int unsigned b0 = sb_m;
    int unsigned m0 = sm_m;
    sq.push_back(mk());
    sq.push_back(mk());
    sq.push_back(mk(.res(1), .mp(1)));
    add_pass(32'h40, 1, 0, -1);
    add_pass(32'h40, 0, 1, -1);
    add_pass(32'h40, 1, 0, -1);
    foreach (sq[k]) begin
      apply(sq[k]);
      @(negedge clk);
      n_cmp++;
      if (stat_branches !== sb_m || stat_mispredicts !== sm_m) begin
        n_err++;
        $display("FAIL stats k=%0d got=%0d/%0d exp=%0d/%0d",
                 k, stat_branches, stat_mispredicts, sb_m, sm_m);
      end
      tick();
    end
    sq.delete();
    @(negedge clk);
    n_cmp++;
    if (stat_branches !== b0 + 3 || stat_mispredicts !== m0 + 1) begin
      n_err++;
      $display("FAIL stats_total got=%0d/%0d exp=%0d/%0d",
               stat_branches, stat_mispredicts, b0 + 3, m0 + 1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_train();
    test_saturation();
    test_flush();
    test_jump();
    test_stall();
    test_same_index();
    test_random();
    test_mid_reset();
`ifdef BP_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
